scarv_cop_stim: RTL
===================

# scarv_cop_stim

Parametrised, synthesisable stimulus sequencer for the CPU/COP instruction interface. It holds a loadable table of instruction encodings and RS1 operands and dispatches them to the COP using a legal request/acknowledge handshake with selectable back-pressure modes. It accepts COP responses under a selectable acceptance mode, bounds the number of outstanding instructions and enforces a cycle timeout. It sits in place of the bench-side CPU stub, so the same stimulus runs in simulation and on FPGA.

## Interface
Parameters:
- DEPTH, 64: instruction/operand table entries (power of two).
- XLEN, 32: encoding and RS1 width.
- MAX_OUT, 2: maximum issued-but-unfinished instructions (1..15).
- CYC_W, 16: cycle/timeout counter width.
- SEED, 32'hACE1_2019: LFSR reset value (non-zero).

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous, active-high reset.
- tbl_wen  in  1  table write strobe; honoured only in IDLE/DONE/TIMEOUT.
- tbl_addr  in  log2(DEPTH)  table write index.
- tbl_enc  in  XLEN  encoding to store.
- tbl_rs1  in  XLEN  RS1 operand to store.
- start  in  1  begin a run (sampled in IDLE/DONE/TIMEOUT).
- n_insn  in  log2(DEPTH)+1  instructions to issue, 0..DEPTH.
- req_mode  in  2  00 always, 01 random (lfsr[0]), 10 sparse (lfsr[2:1]==0), 11 hold-off (never).
- ack_mode  in  2  same coding, using lfsr[3] / lfsr[5:4].
- timeout  in  CYC_W  cycle limit for a run.
- cpu_insn_req  out  1  instruction request.
- cop_insn_ack  in  1  request accepted.
- cpu_insn_enc  out  XLEN  current encoding.
- cpu_rs1  out  XLEN  current RS1 operand.
- cpu_abort_req  out  1  tied 0 this revision.
- cop_insn_rsp  in  1  COP result available.
- cop_result  in  3  COP result code.
- cpu_insn_ack  out  1  result accept.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- timed_out  out  1  state is TIMEOUT.
- n_issued  out  log2(DEPTH)+1  accepted requests this run.
- n_finished  out  log2(DEPTH)+1  accepted responses this run.
- err_cnt  out  log2(DEPTH)+1  finishes with cop_result != 0.
- last_result  out  3  cop_result of the most recent finish.

## Operation
- States: IDLE, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT --start--> RUN. On this transition: clear counters, err_cnt and last_result, and load the cycle counter with 0.
- If start arrives with n_insn==0, go straight to DONE.
- valid = cpu_insn_req & cop_insn_ack. On valid: n_issued++ and the table pointer advances.
- finish = cop_insn_rsp & cpu_insn_ack. On finish: n_finished++, capture last_result, and increment err_cnt if cop_result != 0.
- cpu_insn_enc/cpu_rs1 are driven from table[n_issued[log2(DEPTH)-1:0]]. The read is registered and updated when the pointer moves.
- The request gate is open when all of the following hold: in RUN, n_issued<n_insn, (n_issued-n_finished)<MAX_OUT, and req_mode permits.
- Once cpu_insn_req is asserted it holds, with stable enc/rs1, until valid. Modes only decide when a request is raised, never when it is dropped.
- cpu_insn_ack is registered. Next value = RUN & cop_insn_rsp & ~finish & ack_mode permits. It is therefore high for at most one cycle per response and never acknowledges twice.
- RUN->DONE when n_finished==n_insn.
- RUN->TIMEOUT when the cycle counter == timeout. TIMEOUT wins if both conditions occur in the same cycle.
- In DONE/TIMEOUT, req and ack are low and status is held.
- LFSR: 32-bit Galois, taps 0x8020_0003, advances every cycle, reset to SEED.
- Counters are sized to reach DEPTH exactly, with no wrap. The table pointer wraps modulo DEPTH.

## Timing
- Reset values: all outputs 0, state IDLE, LFSR=SEED. The table contents are not reset.
- Reset mid-run aborts immediately. The table is kept.
- start -> busy on the next edge. The first cpu_insn_req can rise at the earliest one cycle after busy.
- Valid in cycle t: the next entry is presented at t+1, and req may remain high for back-to-back issue.
- Simultaneous valid and finish: outstanding count unchanged.
- When outstanding == MAX_OUT, a new req can rise no earlier than the cycle after a finish.
- done rises on the cycle after the final finish.

## Structure
- Package scarv_cop_stim_pkg holds the state enum, the mode codes, and the LFSR tap constant.
- Sub-module scarv_lfsr32 (SEED parameter, enable input, 32-bit state output) is shared with future random sources.
- Table storage is a plain register array of DEPTH x 2·XLEN.

## Test plan
- Load 4 entries, n_insn=4, req_mode=00, ack_mode=00, MAX_OUT=2, COP responds 1 cycle after ack -> done, n_issued=n_finished=4, enc sequence matches table[0..3].
- COP holds cop_insn_ack low for 5 cycles -> cpu_insn_req and cpu_insn_enc stay stable all 5 cycles; issue occurs exactly once.
- MAX_OUT=1, COP withholds rsp for 10 cycles -> no second req until the cycle after the first finish.
- Responses with cop_result 0,3,0,5 -> err_cnt=2, last_result=5.
- timeout=20, COP never acks -> timed_out at cycle 20, req low afterwards; done=0.
- Assert g_reset mid-run, then start again with n_insn=0 -> all status cleared, done on the next cycle, table intact (a subsequent run reproduces the same encodings).

Source files
------------

// File: rtl/scarv_cop_stim_pkg.sv
// Shared types and constants for the CPU/COP stimulus sequencer.
package scarv_cop_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } stim_state_t;

  localparam logic [1:0] MODE_ALWAYS = 2'b00;
  localparam logic [1:0] MODE_RANDOM = 2'b01;
  localparam logic [1:0] MODE_SPARSE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // rnd_bit drives the 50% mode, rnd_pair==0 the 25% mode.
  function automatic logic mode_permit(input logic [1:0] mode,
                                       input logic       rnd_bit,
                                       input logic [1:0] rnd_pair);
    logic permit;
    case (mode)
      MODE_ALWAYS: permit = 1'b1;
      MODE_RANDOM: permit = rnd_bit;
      MODE_SPARSE: permit = (rnd_pair == 2'b00);
      default:     permit = 1'b0;
    endcase
    return permit;
  endfunction

endpackage

// File: rtl/scarv_cop_stim_lfsr32.sv
// 32-bit Galois LFSR; free-running random source for handshake pacing.
module scarv_lfsr32 #(
  parameter logic [31:0] SEED = 32'hACE1_2019
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        en,
  output logic [31:0] state
);
  import scarv_cop_stim_pkg::*;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= SEED;
    end else if (en) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
    end
  end

endmodule

// File: rtl/scarv_cop_stim.sv
// Table-driven CPU-side stimulus sequencer for the COP instruction interface.
//   state      | meaning
//   ST_IDLE    | after reset, waiting for start; table writable
//   ST_RUN     | issuing requests and accepting responses
//   ST_DONE    | all n_insn responses accepted; status held
//   ST_TIMEOUT | cycle limit reached before completion; status held
module scarv_cop_stim
  import scarv_cop_stim_pkg::*;
#(
  parameter int          DEPTH   = 64,
  parameter int          XLEN    = 32,
  parameter int          MAX_OUT = 2,
  parameter int          CYC_W   = 16,
  parameter logic [31:0] SEED    = 32'hACE1_2019,
  localparam int         AW      = $clog2(DEPTH),
  localparam int         CNT_W   = AW + 1
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             tbl_wen,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [XLEN-1:0]  tbl_enc,
  input  logic [XLEN-1:0]  tbl_rs1,
  input  logic             start,
  input  logic [CNT_W-1:0] n_insn,
  input  logic [1:0]       req_mode,
  input  logic [1:0]       ack_mode,
  input  logic [CYC_W-1:0] timeout,
  output logic             cpu_insn_req,
  input  logic             cop_insn_ack,
  output logic [XLEN-1:0]  cpu_insn_enc,
  output logic [XLEN-1:0]  cpu_rs1,
  output logic             cpu_abort_req,
  input  logic             cop_insn_rsp,
  input  logic [2:0]       cop_result,
  output logic             cpu_insn_ack,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] n_issued,
  output logic [CNT_W-1:0] n_finished,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       last_result
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  stim_state_t         state_q;
  logic [CNT_W-1:0]    iss_q, fin_q, err_q, n_tgt_q;
  logic [CNT_W-1:0]    iss_nxt, fin_nxt, outst_nxt;
  logic [CYC_W-1:0]    cyc_q;
  logic                req_q, ack_q;
  logic [2:0]          last_q;
  logic [XLEN-1:0]     enc_q, rs1_q;
  logic [2*XLEN-1:0]   tbl_mem [DEPTH];
  logic [31:0]         lfsr;
  logic                lfsr_unused;
  logic                valid, finish, req_ok, ack_ok;
  logic                run_stays, gate_open, req_nxt, ack_nxt;

  scarv_lfsr32 #(.SEED(SEED)) u_lfsr (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .en      (1'b1),
    .state   (lfsr)
  );

  assign lfsr_unused = ^lfsr[31:6];

  assign valid     = req_q & cop_insn_ack;
  assign finish    = cop_insn_rsp & ack_q;
  assign iss_nxt   = iss_q + CNT_W'(valid);
  assign fin_nxt   = fin_q + CNT_W'(finish);
  assign outst_nxt = iss_nxt - fin_nxt;
  assign req_ok    = mode_permit(req_mode, lfsr[0], lfsr[2:1]);
  assign ack_ok    = mode_permit(ack_mode, lfsr[3], lfsr[5:4]);

  // Decisions use post-handshake counts so back-to-back issue and
  // refill right after a finish are both possible.
  assign run_stays = (state_q == ST_RUN) && (cyc_q != timeout) && (fin_nxt != n_tgt_q);
  assign gate_open = run_stays && (iss_nxt < n_tgt_q) && (outst_nxt < MAX_OUT_C) && req_ok;
  assign req_nxt   = run_stays && ((req_q && !cop_insn_ack) || gate_open);
  assign ack_nxt   = run_stays && cop_insn_rsp && !finish && ack_ok;

  always_ff @(posedge g_clk) begin
    if (tbl_wen && (state_q != ST_RUN)) begin
      tbl_mem[tbl_addr] <= {tbl_enc, tbl_rs1};
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      iss_q   <= '0;
      fin_q   <= '0;
      err_q   <= '0;
      n_tgt_q <= '0;
      cyc_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      last_q  <= '0;
      enc_q   <= '0;
      rs1_q   <= '0;
    end else begin
      req_q <= req_nxt;
      ack_q <= ack_nxt;
      case (state_q)
        ST_RUN: begin
          cyc_q <= cyc_q + 1'b1;
          iss_q <= iss_nxt;
          fin_q <= fin_nxt;
          if (finish) begin
            last_q <= cop_result;
            if (cop_result != 3'd0) err_q <= err_q + 1'b1;
          end
          if (valid) {enc_q, rs1_q} <= tbl_mem[iss_nxt[AW-1:0]];
          if (cyc_q == timeout)          state_q <= ST_TIMEOUT;
          else if (fin_nxt == n_tgt_q)   state_q <= ST_DONE;
        end
        default: begin
          if (start) begin
            state_q        <= (n_insn == '0) ? ST_DONE : ST_RUN;
            iss_q          <= '0;
            fin_q          <= '0;
            err_q          <= '0;
            last_q         <= '0;
            cyc_q          <= '0;
            n_tgt_q        <= n_insn;
            {enc_q, rs1_q} <= tbl_mem[AW'(0)];
          end
        end
      endcase
    end
  end

  assign cpu_insn_req  = req_q;
  assign cpu_insn_ack  = ack_q;
  assign cpu_insn_enc  = enc_q;
  assign cpu_rs1       = rs1_q;
  assign cpu_abort_req = 1'b0;
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign timed_out     = (state_q == ST_TIMEOUT);
  assign n_issued      = iss_q;
  assign n_finished    = fin_q;
  assign err_cnt       = err_q;
  assign last_result   = last_q;

endmodule
